// File: rtl/noc_pkg.sv
// Shared definitions for the buffered NoC router.
//   NOC_BIT_WIDTH / NOC_ADDR_WIDTH : default request data/address widths
//   noc_req_t                      : request record {data, addr} at default widths;
//                                    the router packs its FIFO words in the same order
//   noc_tag_width()                : source-tag width, never narrower than one bit
package noc_pkg;

  localparam int NOC_BIT_WIDTH  = 32;
  localparam int NOC_ADDR_WIDTH = 16;

  typedef struct packed {
    logic [NOC_BIT_WIDTH-1:0]  data;
    logic [NOC_ADDR_WIDTH-1:0] addr;
  } noc_req_t;

  function automatic int noc_tag_width(input int radix);
    int w;
    w = $clog2(radix);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/noc_req_fifo.sv
// Per-core request FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   full       : count == DEPTH, from the registered count only
//   count      : occupancy 0..DEPTH
//   head       : oldest entry, valid whenever count != 0
module noc_req_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_buffered_router.sv
// Buffered NoC router: RADIX core request channels merged onto one memory port,
// with tagged memory responses routed back to the owning core.
//   clk, rst                              : clock, synchronous active-high reset
//   en/Data/Addr_C2M_IN, rdy_C2M_IN       : per-core request valid/ready handshake
//   en/Data/Addr/Tag_C2M_OUT, rdy_C2M_OUT : registered memory request with backpressure
//   en/Data/Tag_M2C_IN                    : memory response (tag = destination core)
//   en_M2C_OUT, Data_M2C_OUT              : one-hot response valid, shared response data
//   err_tag                               : sticky, a response arrived with tag >= RADIX
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// ready never depends on valid, and a source holds its payload stable until accepted.
module noc_buffered_router
  import noc_pkg::*;
#(
  parameter int RADIX      = 2,
  parameter int BIT_WIDTH  = NOC_BIT_WIDTH,
  parameter int ADDR_WIDTH = NOC_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  localparam int TAG_W     = noc_tag_width(RADIX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RADIX-1:0]            en_C2M_IN,
  input  logic [RADIX*BIT_WIDTH-1:0]  Data_C2M_IN,
  input  logic [RADIX*ADDR_WIDTH-1:0] Addr_C2M_IN,
  output logic [RADIX-1:0]            rdy_C2M_IN,
  output logic                        en_C2M_OUT,
  output logic [BIT_WIDTH-1:0]        Data_C2M_OUT,
  output logic [ADDR_WIDTH-1:0]       Addr_C2M_OUT,
  output logic [TAG_W-1:0]            Tag_C2M_OUT,
  input  logic                        rdy_C2M_OUT,
  input  logic                        en_M2C_IN,
  input  logic [BIT_WIDTH-1:0]        Data_M2C_IN,
  input  logic [TAG_W-1:0]            Tag_M2C_IN,
  output logic [RADIX-1:0]            en_M2C_OUT,
  output logic [BIT_WIDTH-1:0]        Data_M2C_OUT,
  output logic                        err_tag
);

  localparam int REQ_W = BIT_WIDTH + ADDR_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [RADIX-1:0] push;
  logic [RADIX-1:0] pop;
  logic [RADIX-1:0] full;
  logic [RADIX-1:0] pending;
  logic [CW-1:0]    fifo_count [RADIX];
  logic [REQ_W-1:0] fifo_head  [RADIX];

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_valid;
  logic [REQ_W-1:0] grant_head;
  logic             load;
  int               cand;

  // The output register can take a new word when empty or emptying this cycle.
  assign load       = !en_C2M_OUT || rdy_C2M_OUT;
  assign rdy_C2M_IN = ~full;

  for (genvar i = 0; i < RADIX; i++) begin : g_chan
    assign push[i]    = en_C2M_IN[i] && !full[i];
    assign pending[i] = (fifo_count[i] != '0);
    assign pop[i]     = load && grant_valid && (grant_idx == TAG_W'(i));

    noc_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data ({Data_C2M_IN[i*BIT_WIDTH +: BIT_WIDTH], Addr_C2M_IN[i*ADDR_WIDTH +: ADDR_WIDTH]}),
      .pop       (pop[i]),
      .full      (full[i]),
      .count     (fifo_count[i]),
      .head      (fifo_head[i])
    );
  end

  // Round-robin: search starts one past the last granted channel and wraps.
  // rr_ptr < RADIX always, so one subtraction is enough to wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_head  = '0;
    cand        = 0;
    for (int k = 1; k <= RADIX; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= RADIX) cand = cand - RADIX;
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_W'(cand);
        grant_head  = fifo_head[cand];
      end
    end
  end

  // Output stage; fields hold while stalled, and hold on a drain with no successor.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_C2M_OUT   <= 1'b0;
      Data_C2M_OUT <= '0;
      Addr_C2M_OUT <= '0;
      Tag_C2M_OUT  <= '0;
      rr_ptr       <= TAG_W'(RADIX - 1);
    end else if (load) begin
      if (grant_valid) begin
        en_C2M_OUT   <= 1'b1;
        Data_C2M_OUT <= grant_head[REQ_W-1:ADDR_WIDTH];
        Addr_C2M_OUT <= grant_head[ADDR_WIDTH-1:0];
        Tag_C2M_OUT  <= grant_idx;
        rr_ptr       <= grant_idx;
      end else begin
        en_C2M_OUT   <= 1'b0;
      end
    end
  end

  // Response demux: one-cycle registered, out-of-range tags are dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_M2C_OUT   <= '0;
      Data_M2C_OUT <= '0;
      err_tag      <= 1'b0;
    end else begin
      en_M2C_OUT <= '0;
      if (en_M2C_IN) begin
        if (int'(Tag_M2C_IN) < RADIX) begin
          en_M2C_OUT   <= RADIX'(1) << Tag_M2C_IN;
          Data_M2C_OUT <= Data_M2C_IN;
        end else begin
          err_tag <= 1'b1;
        end
      end
    end
  end

endmodule
